xor_arbiter: RTL and testbench
==============================

# xor_arbiter

Round-robin arbiter and sequencer that shares one W-bit bitwise logic unit (XOR / XNOR / XOR|XNOR) between two requesters. Each request carries operands and an opcode. The block grants one requester, registers the operands, computes the result, and holds it until the consumer accepts it. It sits between the operand producers and the shared `xor_unit` datapath, and keeps a wrapping count of completed operations.

## Interface
- `W`, 4, operand/result width in bits (≥1)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req0_valid` in 1, `req0_ready` out 1: requester 0 handshake
- `req0_a`, `req0_b` in W: requester 0 operands
- `req0_op` in 2: requester 0 opcode
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0, for requester 1
- `rsp_valid` out 1, `rsp_ready` in 1: result handshake
- `rsp_data` out W: result
- `rsp_id` out 1: index of the requester that produced the result
- `rsp_err` out 1: reserved opcode was used
- `busy` out 1: a result is held
- `done_cnt` out 8: completed responses, mod 256

## Operation
- FSM has two states.
  - IDLE: accepting requests.
  - RESP: `rsp_valid`=1, result held.
- In IDLE, arbitration is combinational over `req*_valid`.
  - One requester valid: that requester is granted.
  - Both valid: the requester other than `last_id` is granted.
  - The granted `reqN_ready`=1. Every other ready is 0.
  - In RESP, both readies are 0.
- Accept is `reqN_valid & reqN_ready` (IDLE only). On accept:
  - `rsp_data`, `rsp_id`, `rsp_err` are registered from the granted operands.
  - `last_id` ← granted index.
  - Next state is RESP.
- Opcodes:
  - 00: `a^b`
  - 01: `~(a^b)`
  - 10: `(a^b)|~(a^b)`, which is all ones
  - 11: reserved. Result is `a^b` and `rsp_err`=1.
- In RESP, when `rsp_valid & rsp_ready`:
  - Next state is IDLE.
  - `done_cnt` increments, wrapping 255→0.
  - `rsp_data`, `rsp_id`, `rsp_err` keep their values until the next accept.
- In RESP with `rsp_ready`=0, the state and all `rsp_*` outputs are held stable.
- Requester inputs may change freely while that requester's ready is 0. They are sampled only on accept.
- `busy` = (state == RESP).

## Timing
- Reset values:
  - state IDLE
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_err`=0
  - `busy`=0, `done_cnt`=0
  - `last_id`=1, so requester 0 wins the first contention
- Reset asserted mid-operation discards the held result immediately and asynchronously. It is not delivered and is not counted.
- Latency: accept in cycle N → `rsp_valid`=1 in cycle N+1.
- Throughput: at most one operation per 2 cycles. Accept is never possible in the cycle of a response handshake.
- The readies are combinational from state, `last_id` and `req*_valid`. They have no combinational path from `rsp_ready`.
- `rsp_ready` already high when `rsp_valid` rises: the handshake completes in cycle N+1, and IDLE is reached in cycle N+2.

## Configuration
- Macro `XOR_ARBITER_PARITY_EN`.
- Defined: adds output `rsp_parity` (1 bit) = XOR-reduction of `rsp_data`.
  - Registered with `rsp_data`.
  - Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `xor_arbiter_pkg` holds:
  - the opcode localparams `OP_XOR`=2'b00, `OP_XNOR`=2'b01, `OP_ALL`=2'b10, `OP_RSVD`=2'b11
  - the state encoding `ST_IDLE`, `ST_RESP`
- Sub-module `xor_unit`: purely combinational, parameter `W`.
  - Inputs: `a`, `b`, `op`.
  - Outputs: `y`, `err`.
  - It is instantiated once, fed by the grant mux.
- Arbitration, FSM, output registers and counter live in `xor_arbiter`.

## Test plan
- Reset, then idle with no valids: all outputs at reset values, `req0_ready`=`req1_ready`=1 only when the corresponding valid is set.
- `req0` a=0101, b=0110, op=00 with `rsp_ready`=1: next cycle `rsp_data`=0011, `rsp_id`=0, `rsp_err`=0; `done_cnt`=1.
- Both valid every cycle with op=01: grants alternate 0,1,0,1. For a=0101, b=0110, `rsp_data`=1100. Accept cycles are spaced 2 apart.
- `rsp_ready` held 0 for 5 cycles after a result: `rsp_*` stable, both readies 0, `busy`=1. Release → IDLE the next cycle.
- op=11 (a=1111, b=0000): `rsp_data`=1111, `rsp_err`=1. op=10: `rsp_data`=1111, `rsp_err`=0. 256 completions → `done_cnt` wraps to 0.
- `rst_n` pulsed low while in RESP: `rsp_valid` and `busy` go to 0 asynchronously, `done_cnt`=0. With `XOR_ARBITER_PARITY_EN` defined, result 0111 gives `rsp_parity`=1.

Source files
------------

// File: rtl/xor_arbiter_pkg.sv
// Shared definitions for the xor_arbiter block: opcode values and FSM state encoding.
package xor_arbiter_pkg;

  localparam logic [1:0] OP_XOR  = 2'b00;
  localparam logic [1:0] OP_XNOR = 2'b01;
  localparam logic [1:0] OP_ALL  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

endpackage

// File: rtl/xor_unit.sv
// Shared W-bit bitwise logic unit (purely combinational).
// Ports:
//   a, b : operands (W bits)
//   op   : opcode (XOR, XNOR, XOR|XNOR, reserved)
//   y    : result (W bits); reserved opcode yields a^b
//   err  : high when the reserved opcode is presented
module xor_unit
  import xor_arbiter_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] y,
  output logic         err
);

  always_comb begin
    y   = a ^ b;
    err = 1'b0;
    case (op)
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_ALL:  y = (a ^ b) | ~(a ^ b);
      OP_RSVD: err = 1'b1;
      default: err = 1'b0;
    endcase
  end

endmodule

// File: rtl/xor_arbiter.sv
// Round-robin arbiter/sequencer sharing one xor_unit between two requesters.
// Grants one requester in IDLE, registers the result, holds it in RESP until
// the consumer accepts it, and counts completed responses modulo 256.
// Ports:
//   clk, rst_n                          : clock, async active-low reset
//   req{0,1}_valid/_ready/_a/_b/_op     : requester handshakes and payloads
//   rsp_valid, rsp_ready                : result handshake
//   rsp_data, rsp_id, rsp_err           : registered result, source index, reserved-op flag
//   busy                                : a result is being held
//   done_cnt                            : completed responses, wrapping
//   rsp_parity                          : XOR-reduction of rsp_data (only with XOR_ARBITER_PARITY_EN)
// Optional feature macro: XOR_ARBITER_PARITY_EN
module xor_arbiter
  import xor_arbiter_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [1:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic         busy,
  output logic [7:0]   done_cnt
`ifdef XOR_ARBITER_PARITY_EN
  ,
  output logic         rsp_parity
`endif
);

  state_t       state;
  logic         last_id;
  logic         accept;
  logic         gnt_id;
  logic [W-1:0] mux_a;
  logic [W-1:0] mux_b;
  logic [1:0]   mux_op;
  logic [W-1:0] unit_y;
  logic         unit_err;

  // Grant: a lone valid requester wins; on contention the one not served last wins.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == ST_IDLE) begin
      req0_ready = req0_valid & (~req1_valid | last_id);
      req1_ready = req1_valid & (~req0_valid | ~last_id);
    end
  end

  assign accept = req0_ready | req1_ready;
  assign gnt_id = req1_ready;

  assign mux_a  = gnt_id ? req1_a  : req0_a;
  assign mux_b  = gnt_id ? req1_b  : req0_b;
  assign mux_op = gnt_id ? req1_op : req0_op;

  xor_unit #(.W(W)) u_xor_unit (
    .a   (mux_a),
    .b   (mux_b),
    .op  (mux_op),
    .y   (unit_y),
    .err (unit_err)
  );

  // FSM, result registers and completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      last_id   <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      done_cnt  <= 8'd0;
`ifdef XOR_ARBITER_PARITY_EN
      rsp_parity <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_RESP;
            last_id   <= gnt_id;
            rsp_valid <= 1'b1;
            rsp_data  <= unit_y;
            rsp_id    <= gnt_id;
            rsp_err   <= unit_err;
            busy      <= 1'b1;
`ifdef XOR_ARBITER_PARITY_EN
            rsp_parity <= ^unit_y;
`endif
          end
        end
        ST_RESP: begin
          // Result payload is kept after the handshake until the next accept.
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            done_cnt  <= done_cnt + 8'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_arbiter.sv
// Scoreboard bench for xor_arbiter: randomized and directed requests, a
// transaction-level model predicting grants and results, and a monitor that
// checks each presented response against the expected queue.
module tb_xor_arbiter;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic         id;
    logic         err;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_ready;
  logic [W-1:0] req0_a, req0_b;
  logic [1:0]   req0_op;
  logic         req1_valid, req1_ready;
  logic [W-1:0] req1_a, req1_b;
  logic [1:0]   req1_op;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_id, rsp_err, busy;
  logic [7:0]   done_cnt;
`ifdef XOR_ARBITER_PARITY_EN
  logic         rsp_parity;
`endif

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];

  // model state
  bit       m_hold;
  bit       m_last;
  bit [7:0] m_cnt;
  int       mode;

  xor_arbiter #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .done_cnt   (done_cnt)
`ifdef XOR_ARBITER_PARITY_EN
    ,
    .rsp_parity (rsp_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] op, input bit id);
    exp_t e;
    e.id  = id;
    e.err = (op == 2'd3);
    if (op == 2'd2)      e.data = {W{1'b1}};
    else if (op == 2'd1) e.data = ~(a ^ b);
    else                 e.data = a ^ b;
    return e;
  endfunction

  // Winner among current valids; contention goes to the one not served last.
  function automatic bit pick(input bit v0, input bit v1, input bit last);
    if (v0 && v1) return !last;
    return v1;
  endfunction

  task automatic drive();
    req0_valid = 1'($urandom_range(0, 1));
    req1_valid = 1'($urandom_range(0, 1));
    req0_a  = W'($urandom); req0_b = W'($urandom); req0_op = 2'($urandom);
    req1_a  = W'($urandom); req1_b = W'($urandom); req1_op = 2'($urandom);
    rsp_ready = ($urandom_range(0, 3) != 0);
    case (mode)
      1: begin  // both contend, XNOR of fixed operands
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 4'b0101; req0_b = 4'b0110; req0_op = 2'b01;
        req1_a = 4'b0101; req1_b = 4'b0110; req1_op = 2'b01;
        rsp_ready = 1'b1;
      end
      2: rsp_ready = 1'b0;
      3: begin
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = 4'b0101; req0_b = 4'b0110; req0_op = 2'b00;
        rsp_ready = 1'b1;
      end
      4: begin
        req0_valid = 1'b1; req0_a = 4'b1111; req0_b = 4'b0000;
        req0_op = 2'($urandom_range(2, 3));
        rsp_ready = 1'b1;
      end
      5: begin
        req0_valid = 1'b1; rsp_ready = 1'b0;
      end
      default: ;
    endcase
  endtask

  // One cycle: retire the inputs sampled at this edge into the model, drive new ones, check.
  task automatic step();
    bit g;
    @(posedge clk);
    if (rst_n) begin
      if (m_hold) begin
        if (rsp_ready) begin
          m_hold = 1'b0;
          m_cnt  = m_cnt + 8'd1;
        end
      end else if (req0_valid || req1_valid) begin
        g = pick(req0_valid, req1_valid, m_last);
        m_hold = 1'b1;
        m_last = g;
        if (g) exp_q.push_back(calc(req1_a, req1_b, req1_op, 1'b1));
        else   exp_q.push_back(calc(req0_a, req0_b, req0_op, 1'b0));
      end
    end
    #2;
    drive();
    #1;
    g = pick(req0_valid, req1_valid, m_last);
    chk("req0_ready", 32'(req0_ready), 32'(!m_hold && req0_valid && (g == 1'b0)));
    chk("req1_ready", 32'(req1_ready), 32'(!m_hold && req1_valid && (g == 1'b1)));
    chk("busy",       32'(busy),       32'(m_hold));
    chk("rsp_valid",  32'(rsp_valid),  32'(m_hold));
    chk("done_cnt",   32'(done_cnt),   32'(m_cnt));
  endtask

  task automatic run(input int m, input int n);
    mode = m;
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compare every presented response with the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
        chk("rsp_id",   32'(rsp_id),   32'(exp_q[0].id));
        chk("rsp_err",  32'(rsp_err),  32'(exp_q[0].err));
`ifdef XOR_ARBITER_PARITY_EN
        chk("rsp_parity", 32'(rsp_parity), 32'(^exp_q[0].data));
`endif
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic model_reset();
    exp_q.delete();
    m_hold = 1'b0;
    m_last = 1'b1;
    m_cnt  = 8'd0;
  endtask

  initial begin
    int guard;
    model_reset();
    mode = 0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done_cnt",  32'(done_cnt),  32'd0);
    chk("idle_ready0",   32'(req0_ready), 32'd0);
    chk("idle_ready1",   32'(req1_ready), 32'd0);
    req1_valid = 1'b1;
    #1;
    chk("idle_v1_ready1", 32'(req1_ready), 32'd1);
    chk("idle_v1_ready0", 32'(req0_ready), 32'd0);
    req0_valid = 1'b1;
    #1;
    chk("first_contention_r0", 32'(req0_ready), 32'd1);
    chk("first_contention_r1", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run(3, 2);     // single req0 XOR
    run(0, 4);
    run(1, 20);    // alternating grants
    run(5, 2);
    run(2, 5);     // stalled consumer
    run(1, 4);
    run(4, 20);    // reserved / all-ones opcodes
    run(1, 560);   // enough completions to wrap done_cnt
    run(0, 2000);

    // Reset while a result is held.
    mode = 5;
    guard = 0;
    while (!m_hold && guard < 20) begin
      step();
      guard++;
    end
    chk("hold_before_reset", 32'(m_hold), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_busy",      32'(busy),      32'd0);
    chk("async_rst_done_cnt",  32'(done_cnt),  32'd0);
    model_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 300);
    run(1, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
